// File: rtl/switch_port_scheduler_pkg.sv
// Shared types and constants for the 4-port switch scheduler.
package switch_port_scheduler_pkg;

  localparam int NUM_PORTS = 4;
  localparam int SEL_W     = 2;

  typedef logic [NUM_PORTS-1:0] port_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2
  } sched_state_t;

  // Round-robin pointer update: one past the first granted input found
  // when scanning from ptr; unchanged when nothing was granted.
  function automatic logic [SEL_W-1:0] rr_next(input port_vec_t gnt,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_next = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && gnt[idx]) begin
        rr_next = idx + 1'b1;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/switch_port_scheduler_if.sv
// Request/grant bundle between the switch input ports and the scheduler.
//
// Handshake: req[i] is the valid, grant[i] the one-cycle accept. Once req[i]
// rises, the requester holds req[i] high and target[i] stable until it sees
// grant[i]; the transfer then lasts until eop[i] (or a watchdog timeout).
interface switch_port_scheduler_if;
  import switch_port_scheduler_pkg::*;

  logic [NUM_PORTS-1:0]           req;
  logic [NUM_PORTS*NUM_PORTS-1:0] target;
  logic [NUM_PORTS-1:0]           eop;
  logic [NUM_PORTS-1:0]           suspend;
  logic [NUM_PORTS-1:0]           grant;
  logic [NUM_PORTS-1:0]           active;
  logic [NUM_PORTS-1:0]           out_busy;
  logic [NUM_PORTS*SEL_W-1:0]     out_sel;
  logic [NUM_PORTS-1:0]           err_target;
  logic [NUM_PORTS-1:0]           timeout;
  // Debug view: per-input FSM state (2 bits each) and round-robin pointer.
  logic [2*NUM_PORTS-1:0]         dbg_state;
  logic [SEL_W-1:0]               dbg_rr_ptr;

  modport master (
    output req, target, eop, suspend,
    input  grant, active, out_busy, out_sel, err_target, timeout,
    input  dbg_state, dbg_rr_ptr
  );

  modport slave (
    input  req, target, eop, suspend,
    output grant, active, out_busy, out_sel, err_target, timeout,
    output dbg_state, dbg_rr_ptr
  );

endinterface

// File: rtl/switch_port_scheduler_rr_alloc.sv
// Combinational round-robin allocator: grants every waiting input whose
// whole target set is free and not already claimed earlier in the scan.
module switch_rr_alloc
  import switch_port_scheduler_pkg::*;
(
  input  port_vec_t        wait_vec,
  input  port_vec_t        targets [NUM_PORTS],
  input  port_vec_t        free_vec,
  input  logic [SEL_W-1:0] rr_ptr,
  output port_vec_t        grant_vec,
  output port_vec_t        claimed_vec
);

  logic [SEL_W-1:0] idx;
  port_vec_t        tgt;

  // Scan from rr_ptr; a claim is all-or-nothing across the target set.
  always_comb begin
    grant_vec   = '0;
    claimed_vec = '0;
    idx         = '0;
    tgt         = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = rr_ptr + SEL_W'(k);
      tgt = targets[idx];
      if (wait_vec[idx] && (tgt != '0) &&
          ((tgt & ~free_vec) == '0) && ((tgt & claimed_vec) == '0)) begin
        grant_vec[idx] = 1'b1;
        claimed_vec    = claimed_vec | tgt;
      end
    end
  end

endmodule

// File: rtl/switch_port_scheduler.sv
// Central scheduler: per-input request FSMs, output ownership, round-robin
// pointer and per-input stuck-packet watchdogs.
module switch_port_scheduler
  import switch_port_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input logic               clk,
  input logic               reset,
  switch_port_scheduler_if.slave sif
);

  localparam bit              WD_EN   = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  sched_state_t     state_q [NUM_PORTS];
  sched_state_t     state_d [NUM_PORTS];
  logic [SEL_W-1:0] out_sel_q [NUM_PORTS];
  logic [SEL_W-1:0] out_sel_d [NUM_PORTS];
  logic [TO_W-1:0]  wd_q [NUM_PORTS];
  logic [TO_W-1:0]  wd_d [NUM_PORTS];
  port_vec_t        out_busy_q, out_busy_d;
  port_vec_t        grant_q, grant_d;
  port_vec_t        timeout_q, timeout_d;
  port_vec_t        err_q, err_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  port_vec_t tgt_a [NUM_PORTS];
  port_vec_t wait_vec, free_vec, alloc_grant, alloc_claimed, release_vec;

  // Unpack targets and form allocator inputs from registered state.
  always_comb begin
    wait_vec = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      tgt_a[i]    = sif.target[i*NUM_PORTS +: NUM_PORTS];
      wait_vec[i] = (state_q[i] == WAIT) && sif.req[i];
    end
    free_vec = ~out_busy_q & ~sif.suspend;
  end

  switch_rr_alloc u_alloc (
    .wait_vec    (wait_vec),
    .targets     (tgt_a),
    .free_vec    (free_vec),
    .rr_ptr      (rr_ptr_q),
    .grant_vec   (alloc_grant),
    .claimed_vec (alloc_claimed)
  );

  // Next state: FSM transitions, watchdog, release then claim of outputs.
  always_comb begin
    state_d     = state_q;
    out_sel_d   = out_sel_q;
    wd_d        = wd_q;
    out_busy_d  = out_busy_q;
    timeout_d   = '0;
    err_d       = '0;
    release_vec = '0;
    grant_d     = alloc_grant;
    rr_ptr_d    = rr_next(alloc_grant, rr_ptr_q);

    for (int i = 0; i < NUM_PORTS; i++) begin
      err_d[i] = sif.req[i] && (tgt_a[i] == '0);
      unique case (state_q[i])
        IDLE: begin
          if (sif.req[i] && (tgt_a[i] != '0)) state_d[i] = WAIT;
        end
        WAIT: begin
          if (alloc_grant[i]) begin
            state_d[i] = ACTIVE;
            wd_d[i]    = '0;
          end else if (!sif.req[i]) begin
            state_d[i] = IDLE;
          end
        end
        ACTIVE: begin
          // eop wins over a coinciding expiry, so no timeout pulse then.
          if (sif.eop[i]) begin
            release_vec[i] = 1'b1;
            state_d[i]     = IDLE;
          end else if (WD_EN && (wd_q[i] == TO_LAST)) begin
            release_vec[i] = 1'b1;
            timeout_d[i]   = 1'b1;
            state_d[i]     = IDLE;
          end else begin
            wd_d[i] = wd_q[i] + 1'b1;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end

    // Released outputs stay busy in the registered view this edge, so they
    // cannot be re-claimed before the following edge.
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (out_busy_q[o] && release_vec[out_sel_q[o]]) out_busy_d[o] = 1'b0;
      if (alloc_claimed[o]) out_busy_d[o] = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (alloc_grant[i] && tgt_a[i][o]) out_sel_d[o] = SEL_W'(i);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i]   <= IDLE;
        out_sel_q[i] <= '0;
        wd_q[i]      <= '0;
      end
      out_busy_q <= '0;
      grant_q    <= '0;
      timeout_q  <= '0;
      err_q      <= '0;
      rr_ptr_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i]   <= state_d[i];
        out_sel_q[i] <= out_sel_d[i];
        wd_q[i]      <= wd_d[i];
      end
      out_busy_q <= out_busy_d;
      grant_q    <= grant_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Drive the interface outputs from registered state.
  always_comb begin
    sif.active    = '0;
    sif.out_sel   = '0;
    sif.dbg_state = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      sif.active[o]                 = (state_q[o] == ACTIVE);
      sif.out_sel[o*SEL_W +: SEL_W] = out_sel_q[o];
      sif.dbg_state[o*2 +: 2]       = state_q[o];
    end
    sif.grant      = grant_q;
    sif.out_busy   = out_busy_q;
    sif.err_target = err_q;
    sif.timeout    = timeout_q;
    sif.dbg_rr_ptr = rr_ptr_q;
  end

endmodule

// File: doc/switch_port_scheduler.md
Name: switch_port_scheduler

Overview:
- Central scheduler for the 4-port packet switch.
- Takes per-input transfer requests (target vector taken from packet.target) and allocates output ports to them.
- Single, multicast and broadcast packets are granted atomically: every target output is claimed in the same cycle.
- Owns output-port busy/ownership state, round-robin fairness, per-output suspend gating, and a stuck-packet watchdog. Output mux selects come from this block.

Parameters:
- NUM_PORTS, 4, number of switch ports; the design is only required to be correct at 4.
- SEL_W, 2, width of one output-select field, equal to log2(NUM_PORTS).
- TIMEOUT, 256, cycles an input may hold ownership without eop before forced release; 0 disables the watchdog.
- TO_W, 9, width of each watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  switch clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_PORTS  input i has a packet pending; held with target stable until grant[i].
- target  in  NUM_PORTS*NUM_PORTS  target vector for input i in bits [4i+3:4i].
- eop  in  NUM_PORTS  last-data-cycle strobe from input i.
- suspend  in  NUM_PORTS  output o suspended (port_if suspend_ip); blocks new claims only.
- grant  out  NUM_PORTS  one-cycle pulse: input i now owns every output in its target.
- active  out  NUM_PORTS  input i currently owns outputs.
- out_busy  out  NUM_PORTS  output o owned.
- out_sel  out  NUM_PORTS*SEL_W  owning input index for output o, bits [2o+1:2o]; valid only when out_busy[o].
- err_target  out  NUM_PORTS  registered level: req[i] with target==0.
- timeout  out  NUM_PORTS  one-cycle pulse: watchdog force-released input i.

Behaviour:
- Reset (async): grant, active, out_busy, out_sel, err_target and timeout are all 0. rr_ptr = 0. Watchdog counters = 0. Every input FSM is in IDLE.
- Per-input FSM states are IDLE, WAIT and ACTIVE.
  - IDLE -> WAIT when req[i]=1 and target[i]!=0.
  - WAIT -> ACTIVE on allocation.
  - ACTIVE -> IDLE on eop[i] or watchdog expiry.
  - WAIT -> IDLE if req drops.
- Allocation runs each edge on registered state:
  - Scan inputs in order rr_ptr, rr_ptr+1, ... (mod 4).
  - Input i is eligible when it is in WAIT, and every output in target[i] is not busy, not suspended, and not claimed by an earlier input in this scan.
  - Multiple non-conflicting inputs may be granted in the same edge.
- Latency:
  - req sampled at edge N gives grant, active, out_busy and out_sel visible after edge N+1 at the earliest.
  - An input in IDLE at edge N moves to WAIT at N; allocation happens at N+1.
- rr_ptr: after an edge with at least one grant, rr_ptr = (first granted input in scan order) + 1 mod 4. It is unchanged when nothing is granted.
- Release: eop[i] sampled while ACTIVE clears out_busy for all outputs owned by i at that edge. The freed outputs are allocatable from the following edge, so new grant pulses appear at the earliest 2 cycles after eop.
- Ignored events:
  - eop[i] while not ACTIVE is ignored.
  - req[i] while ACTIVE is ignored; re-request is evaluated only after return to IDLE.
- suspend:
  - Checked only at allocation.
  - Asserting suspend on an owned output does not revoke ownership.
  - A multicast waits until all its target outputs are unsuspended.
- Broadcast (target=4'hf) claims all four outputs. It needs every output idle and unsuspended, and it blocks all other inputs until release.
- Watchdog (TIMEOUT>0):
  - Counter i resets on grant and increments each ACTIVE cycle.
  - Reaching TIMEOUT with no eop forces release exactly like eop and pulses timeout[i].
  - When eop coincides with expiry, eop wins and timeout is not pulsed.
- Zero target: err_target[i] tracks req[i]&&(target[i]==0) with one cycle of latency; the input is never granted.
- Source/target overlap is not checked; that is a checker responsibility.

Decomposition:
- packet_pkg additions:
  - NUM_PORTS constant.
  - port_vec_t (logic[3:0]).
  - sched_state_t enum {IDLE, WAIT, ACTIVE}.
- One combinational sub-module, switch_rr_alloc:
  - Inputs: wait vector, targets, free vector (~out_busy & ~suspend), rr_ptr.
  - Outputs: grant vector and claimed-output vector.
- The top level holds the FSMs, ownership registers, rr_ptr and watchdogs.

Test Plan:
- Reset mid-ACTIVE: input 1 owns output 2, assert reset -> all outputs 0 immediately (async), rr_ptr=0, and a fresh req is granted normally after release.
- Contention: req=4'b0011, target0=4'b0100, target1=4'b0100, rr_ptr=0 -> grant=4'b0001 after 2 edges, out_sel[5:4]=0. After eop0, grant=4'b0010 two cycles later and out_sel[5:4]=1.
- Parallel + multicast: target0=4'b1000, target2=4'b0011, same cycle -> both granted in one pulse, out_busy=4'b1011, rr_ptr=1.
- Broadcast blocking: input 3 active on output 0, input 0 requests 4'hf -> no grant until eop3. Input 1 request 4'b0100 arriving meanwhile is granted first; broadcast is granted only when all four are free.
- Suspend: suspend=4'b0010, input 0 target=4'b0010 -> no grant. Deassert suspend -> grant on the next edge. Asserting suspend while owned leaves out_busy=1.
- Watchdog with TIMEOUT=8: grant input 2 with no eop -> timeout[2] pulses 8 cycles after grant and out_busy is cleared. Zero target on input 3 -> err_target[3]=1 and never granted.
